dmem_responder: RTL and testbench
=================================

# dmem_responder

Data-memory responder for the pipelined RISC-V core: services load/store requests issued by the MEM stage over a valid/ready request channel and returns results on a valid/ready response channel. Stores and loads follow RV32I funct3 semantics (byte/half/word, signed/unsigned loads). A programmable wait-state counter models slow memory so the pipeline stall logic can be exercised.

## Interface
- DM_ADDRESS, 9, byte-address width (512 B space)
- DATA_W, 32, data width
- WAIT_CYCLES, 1, wait states between acceptance and access (0..15)
- clk  input  1  clock, rising edge
- reset  input  1  asynchronous, active-low reset
- req_valid  input  1  request present
- req_ready  output  1  responder can accept a request
- req_wr  input  1  1 = store, 0 = load
- req_addr  input  DM_ADDRESS  byte address
- req_wdata  input  DATA_W  store data (low bytes used for SB/SH)
- req_funct3  input  3  RV32I access size/sign code
- resp_valid  output  1  response present
- resp_ready  input  1  consumer accepts response
- resp_rdata  output  DATA_W  load result, extended per funct3; 0 for stores and errors
- resp_err  output  1  misaligned or illegal funct3

## Operation
- Storage: 2^(DM_ADDRESS-2) x DATA_W words, indexed by addr[DM_ADDRESS-1:2]; contents not reset.
- States: IDLE, WAIT, RESP.
- IDLE: req_ready=1. On req_valid&&req_ready latch wr, addr, wdata, funct3; go WAIT with counter=WAIT_CYCLES-1, or straight to access if WAIT_CYCLES=0.
- WAIT: req_ready=0; counter decrements each cycle; at 0 perform access and go RESP.
- Access (single edge): check legality; store writes enabled byte lanes; load extracts/extends lane into resp_rdata register.
- RESP: resp_valid=1, outputs stable until resp_valid&&resp_ready, then IDLE.
- funct3 loads: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU; others illegal. Stores: 000 SB, 001 SH, 010 SW; others illegal.
- Misaligned: half with addr[0]=1, word with addr[1:0]!=0.
- Error (illegal or misaligned): resp_err=1, resp_rdata=0, memory unchanged.
- Byte lane = addr[1:0]; SB writes req_wdata[7:0] to lane; SH writes [15:0] to lanes {addr[1],0}+1..0.
- Sign extension from bit 7 (LB) or 15 (LH); zero-extension for LBU/LHU.
- Requests while not IDLE are ignored (req_ready=0); requester must hold req_valid.

## Timing
- Reset (asserted, async): state IDLE, req_ready=1 after reset deassert, resp_valid=0, resp_rdata=0, resp_err=0, counter=0.
- Latency: acceptance at edge t; memory access/store commit at edge t+WAIT_CYCLES+1... precisely: resp_valid high in cycle following edge t+WAIT_CYCLES (WAIT_CYCLES=0: one cycle after acceptance).
- Store commits at the same edge resp_valid rises; a load issued after the response handshake observes it.
- Throughput: one request per WAIT_CYCLES+2 cycles with resp_ready tied high (accept, waits, response, return to IDLE).
- resp_ready low: RESP held indefinitely, no new acceptance.
- Reset mid-WAIT: pending store dropped, no response produced; reset mid-RESP: response discarded.
- Registered outputs only; no combinational path from req_* to resp_*.

## Structure
- Package dmem_pkg: state enum (IDLE, WAIT, RESP), funct3 constants F3_B/F3_H/F3_W/F3_BU/F3_HU, WAIT counter width (4).
- Sub-module dmem_lane_align (combinational): from addr[1:0], funct3, wdata, read word -> byte-enable mask, merged write word, extended load data, error flag.
- Top: FSM, wait counter, request latch, memory array, response registers.

## Test plan
- WAIT_CYCLES=1: SW 0xDEADBEEF @0x010, then LW @0x010 -> resp_rdata=0xDEADBEEF, resp_err=0, resp_valid 2 cycles after each acceptance.
- After above, SB 0x7F @0x013; LW @0x010 -> 0x7FADBEEF; LB @0x013 -> 0x0000007F; LB @0x012 -> 0xFFFFFFAD; LBU @0x012 -> 0x000000AD.
- SH 0x8001 @0x022; LH @0x022 -> 0xFFFF8001; LHU -> 0x00008001; LW @0x020 -> upper half 0x8001.
- LW @0x011 and SH @0x013 -> resp_err=1, resp_rdata=0; subsequent LW @0x010 unchanged; funct3=011 load -> resp_err=1.
- resp_ready held low 5 cycles in RESP -> resp_valid, resp_rdata stable, req_ready=0; release -> IDLE next cycle.
- Assert reset during WAIT of SW 0x12345678 @0x030 (prior value 0) -> outputs zero immediately, no response; LW @0x030 -> 0x00000000.

Source files
------------

// File: rtl/dmem_pkg.sv
// dmem_pkg
// Shared definitions for the data-memory responder:
//   state_e      responder FSM states (IDLE, WAIT, RESP)
//   F3_*         RV32I load/store funct3 codes for access size and sign
//   CNT_W        width of the wait-state counter (supports 0..15 waits)
package dmem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_e;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam int CNT_W = 4;

endpackage

// File: rtl/dmem_responder_if.sv
// dmem_responder_if
// Request/response bus between the MEM stage (master) and the data memory
// responder (slave).
//   req_valid/req_ready    request handshake
//   req_wr                 1 = store, 0 = load
//   req_addr               byte address
//   req_wdata              store data (low bytes used for SB/SH)
//   req_funct3             RV32I access size/sign code
//   resp_valid/resp_ready  response handshake
//   resp_rdata             extended load data, 0 for stores and errors
//   resp_err               misaligned access or illegal funct3
interface dmem_responder_if #(
  parameter int DM_ADDRESS = 9,
  parameter int DATA_W     = 32
);

  logic                  req_valid;
  logic                  req_ready;
  logic                  req_wr;
  logic [DM_ADDRESS-1:0] req_addr;
  logic [DATA_W-1:0]     req_wdata;
  logic [2:0]            req_funct3;
  logic                  resp_valid;
  logic                  resp_ready;
  logic [DATA_W-1:0]     resp_rdata;
  logic                  resp_err;

  modport master (
    output req_valid, req_wr, req_addr, req_wdata, req_funct3, resp_ready,
    input  req_ready, resp_valid, resp_rdata, resp_err
  );

  modport slave (
    input  req_valid, req_wr, req_addr, req_wdata, req_funct3, resp_ready,
    output req_ready, resp_valid, resp_rdata, resp_err
  );

endinterface

// File: rtl/dmem_lane_align.sv
// dmem_lane_align
// Combinational byte-lane logic for one 32-bit memory word.
//   addr_i    byte offset within the word (addr[1:0])
//   funct3_i  RV32I size/sign code
//   wr_i      1 = store, 0 = load
//   wdata_i   raw store data from the requester
//   rword_i   current contents of the addressed word
//   be_o      byte lanes to write (all zero on error or load)
//   wword_o   rword_i with the enabled lanes replaced by store data
//   rdata_o   extended load result (zero for stores and errors)
//   err_o     misaligned access or illegal funct3 for this direction
module dmem_lane_align
  import dmem_pkg::*;
(
  input  logic [1:0]  addr_i,
  input  logic [2:0]  funct3_i,
  input  logic        wr_i,
  input  logic [31:0] wdata_i,
  input  logic [31:0] rword_i,
  output logic [3:0]  be_o,
  output logic [31:0] wword_o,
  output logic [31:0] rdata_o,
  output logic        err_o
);

  logic [7:0]  byteSel;
  logic [15:0] halfSel;
  logic [31:0] replData;
  logic [3:0]  laneMask;
  logic [31:0] loadData;

  // Pick the addressed byte/half out of the read word.
  always_comb begin
    byteSel = rword_i[{addr_i, 3'b000} +: 8];
    halfSel = addr_i[1] ? rword_i[31:16] : rword_i[15:0];
  end

  // Decode size/sign. Store data is replicated across the word so the
  // lane mask alone decides which bytes land in memory. Unsigned codes
  // only exist for loads, so they flag an error when used as stores.
  always_comb begin
    laneMask = 4'b0000;
    replData = wdata_i;
    loadData = '0;
    err_o    = 1'b0;
    case (funct3_i)
      F3_B: begin
        laneMask = 4'b0001 << addr_i;
        replData = {4{wdata_i[7:0]}};
        loadData = {{24{byteSel[7]}}, byteSel};
      end
      F3_H: begin
        err_o    = addr_i[0];
        laneMask = addr_i[1] ? 4'b1100 : 4'b0011;
        replData = {2{wdata_i[15:0]}};
        loadData = {{16{halfSel[15]}}, halfSel};
      end
      F3_W: begin
        err_o    = (addr_i != 2'b00);
        laneMask = 4'b1111;
        loadData = rword_i;
      end
      F3_BU: begin
        err_o    = wr_i;
        loadData = {24'd0, byteSel};
      end
      F3_HU: begin
        err_o    = wr_i | addr_i[0];
        loadData = {16'd0, halfSel};
      end
      default: begin
        err_o = 1'b1;
      end
    endcase
  end

  // Errors suppress both the write and the load data; stores return zero.
  always_comb begin
    be_o    = (err_o || !wr_i) ? 4'b0000 : laneMask;
    rdata_o = (err_o || wr_i) ? 32'd0 : loadData;
    for (int i = 0; i < 4; i++) begin
      wword_o[8*i +: 8] = be_o[i] ? replData[8*i +: 8] : rword_i[8*i +: 8];
    end
  end

endmodule

// File: rtl/dmem_responder.sv
// dmem_responder
// Data-memory responder for the pipelined core. Accepts one load/store at a
// time, waits WAIT_CYCLES cycles to model slow memory, performs the access
// on a single edge and holds the registered response until it is taken.
//   clk    rising-edge clock
//   reset  asynchronous, active-low reset
//   bus    dmem_responder_if slave modport (request and response channels)
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int DM_ADDRESS  = 9,
  parameter int DATA_W      = 32,
  parameter int WAIT_CYCLES = 1
) (
  input  logic          clk,
  input  logic          reset,
  dmem_responder_if.slave bus
);

  localparam int DEPTH = 2 ** (DM_ADDRESS - 2);
  localparam logic [CNT_W-1:0] WAIT_INIT =
    (WAIT_CYCLES == 0) ? '0 : CNT_W'(WAIT_CYCLES - 1);

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                wr_q;
  logic [DM_ADDRESS-1:0] addr_q;
  logic [DATA_W-1:0]   wdata_q;
  logic [2:0]          funct3_q;
  logic [DATA_W-1:0]   rdata_q;
  logic                err_q;

  logic [DATA_W-1:0]   mem [DEPTH];

  logic                doAccess;
  logic                fromReq;
  logic                accWr;
  logic [DM_ADDRESS-1:0] accAddr;
  logic [DATA_W-1:0]   accWdata;
  logic [2:0]          accFunct3;
  logic [DATA_W-1:0]   readWord;
  logic [3:0]          alignBe;
  logic [DATA_W-1:0]   alignWword;
  logic [DATA_W-1:0]   alignRdata;
  logic                alignErr;

  // With zero wait states the access happens on the accepting edge, so the
  // access operands come straight from the request; otherwise from the latch.
  always_comb begin
    fromReq   = (state_q == IDLE);
    accWr     = fromReq ? bus.req_wr     : wr_q;
    accAddr   = fromReq ? bus.req_addr   : addr_q;
    accWdata  = fromReq ? bus.req_wdata  : wdata_q;
    accFunct3 = fromReq ? bus.req_funct3 : funct3_q;
    readWord  = mem[accAddr[DM_ADDRESS-1:2]];
  end

  dmem_lane_align u_align (
    .addr_i   (accAddr[1:0]),
    .funct3_i (accFunct3),
    .wr_i     (accWr),
    .wdata_i  (accWdata),
    .rword_i  (readWord),
    .be_o     (alignBe),
    .wword_o  (alignWword),
    .rdata_o  (alignRdata),
    .err_o    (alignErr)
  );

  // Next-state logic; doAccess marks the single edge on which memory is
  // written and the response registers are loaded.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    doAccess = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.req_valid) begin
          if (WAIT_CYCLES == 0) begin
            state_d  = RESP;
            doAccess = 1'b1;
          end else begin
            state_d = WAIT;
            cnt_d   = WAIT_INIT;
          end
        end
      end
      WAIT: begin
        if (cnt_q == '0) begin
          state_d  = RESP;
          doAccess = 1'b1;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      RESP: begin
        if (bus.resp_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Request latch, loaded on acceptance.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      funct3_q <= '0;
    end else if (state_q == IDLE && bus.req_valid) begin
      wr_q     <= bus.req_wr;
      addr_q   <= bus.req_addr;
      wdata_q  <= bus.req_wdata;
      funct3_q <= bus.req_funct3;
    end
  end

  // Response registers; they change only on the access edge so the
  // response stays stable while the consumer stalls.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else if (doAccess) begin
      rdata_q <= alignRdata;
      err_q   <= alignErr;
    end
  end

  // Storage is not reset. The reset term keeps a zero-wait request seen
  // while reset is held from slipping a write in.
  always_ff @(posedge clk) begin
    if (doAccess && reset && (|alignBe)) begin
      mem[accAddr[DM_ADDRESS-1:2]] <= alignWword;
    end
  end

  assign bus.req_ready  = (state_q == IDLE);
  assign bus.resp_valid = (state_q == RESP);
  assign bus.resp_rdata = rdata_q;
  assign bus.resp_err   = err_q;

endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder
// Directed scoreboard bench for dmem_responder: each request pushes its
// expected response, which is popped and compared when resp_valid rises.
module tb_dmem_responder;

  localparam int DM_ADDRESS  = 9;
  localparam int DATA_W      = 32;
  localparam int WAIT_CYCLES = 1;

  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  logic clk;
  logic reset;
  int   checks;
  int   errors;
  exp_t sbQ[$];

  dmem_responder_if #(.DM_ADDRESS(DM_ADDRESS), .DATA_W(DATA_W)) bus ();

  dmem_responder #(
    .DM_ADDRESS  (DM_ADDRESS),
    .DATA_W      (DATA_W),
    .WAIT_CYCLES (WAIT_CYCLES)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  // Free-running 10 ns clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Single comparison point shared by every check.
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Pops the scoreboard entry for the response now on the bus, optionally
  // stalls the consumer for holdCycles, then completes the handshake.
  task automatic checkOutput(input string tag, input int lat, input int holdCycles);
    exp_t e;
    check({tag, "_sb_nonempty"}, 32'(sbQ.size() > 0), 32'd1);
    if (sbQ.size() > 0) begin
      e = sbQ.pop_front();
      check({tag, "_latency"}, 32'(lat), 32'(WAIT_CYCLES));
      check({tag, "_rdata"}, bus.resp_rdata, e.rdata);
      check({tag, "_err"}, 32'(bus.resp_err), 32'(e.err));
      for (int i = 0; i < holdCycles; i++) begin
        @(posedge clk);
        #1;
        check({tag, "_hold_valid"}, 32'(bus.resp_valid), 32'd1);
        check({tag, "_hold_rdata"}, bus.resp_rdata, e.rdata);
        check({tag, "_hold_err"}, 32'(bus.resp_err), 32'(e.err));
        check({tag, "_hold_ready"}, 32'(bus.req_ready), 32'd0);
      end
      bus.resp_ready = 1'b1;
    end
    @(posedge clk);
    #1;
    check({tag, "_done_valid"}, 32'(bus.resp_valid), 32'd0);
    check({tag, "_done_ready"}, 32'(bus.req_ready), 32'd1);
  endtask

  // Issues one request, records its expected response and waits (bounded)
  // for acceptance and for the response.
  task automatic applyStimulus(input logic wr, input logic [8:0] addr, input logic [31:0] wdata,
                               input logic [2:0] f3, input logic [31:0] expData, input logic expErr,
                               input int holdCycles, input string tag);
    int n;
    int lat;
    @(negedge clk);
    bus.req_valid  = 1'b1;
    bus.req_wr     = wr;
    bus.req_addr   = addr;
    bus.req_wdata  = wdata;
    bus.req_funct3 = f3;
    if (holdCycles > 0) bus.resp_ready = 1'b0;
    sbQ.push_back({expData, expErr});
    n = 0;
    while (!bus.req_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_accept_bound"}, 32'(n < 50), 32'd1);
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    check({tag, "_busy_ready"}, 32'(bus.req_ready), 32'd0);
    lat = 0;
    while (!bus.resp_valid && lat < 50) begin
      @(posedge clk);
      #1;
      lat++;
    end
    checkOutput(tag, lat, holdCycles);
  endtask

  initial begin
    checks         = 0;
    errors         = 0;
    reset          = 1'b0;
    bus.req_valid  = 1'b0;
    bus.req_wr     = 1'b0;
    bus.req_addr   = '0;
    bus.req_wdata  = '0;
    bus.req_funct3 = '0;
    bus.resp_ready = 1'b1;

    repeat (2) @(posedge clk);
    #1;
    check("rst_resp_valid", 32'(bus.resp_valid), 32'd0);
    check("rst_resp_rdata", bus.resp_rdata, 32'd0);
    check("rst_resp_err", 32'(bus.resp_err), 32'd0);
    check("rst_req_ready", 32'(bus.req_ready), 32'd1);
    @(negedge clk);
    reset = 1'b1;

    // Known contents for the words whose untouched bytes get read later.
    applyStimulus(1'b1, 9'h030, 32'h0000_0000, 3'b010, 32'h0000_0000, 1'b0, 0, "sw_init30");
    applyStimulus(1'b1, 9'h020, 32'h0000_0000, 3'b010, 32'h0000_0000, 1'b0, 0, "sw_init20");

    applyStimulus(1'b1, 9'h010, 32'hDEAD_BEEF, 3'b010, 32'h0000_0000, 1'b0, 0, "sw_10");
    applyStimulus(1'b0, 9'h010, 32'h0,         3'b010, 32'hDEAD_BEEF, 1'b0, 0, "lw_10");

    applyStimulus(1'b1, 9'h013, 32'h0000_007F, 3'b000, 32'h0000_0000, 1'b0, 0, "sb_13");
    applyStimulus(1'b0, 9'h010, 32'h0,         3'b010, 32'h7FAD_BEEF, 1'b0, 0, "lw_10_b");
    applyStimulus(1'b0, 9'h013, 32'h0,         3'b000, 32'h0000_007F, 1'b0, 0, "lb_13");
    applyStimulus(1'b0, 9'h012, 32'h0,         3'b000, 32'hFFFF_FFAD, 1'b0, 0, "lb_12");
    applyStimulus(1'b0, 9'h012, 32'h0,         3'b100, 32'h0000_00AD, 1'b0, 0, "lbu_12");

    applyStimulus(1'b1, 9'h022, 32'h0000_8001, 3'b001, 32'h0000_0000, 1'b0, 0, "sh_22");
    applyStimulus(1'b0, 9'h022, 32'h0,         3'b001, 32'hFFFF_8001, 1'b0, 0, "lh_22");
    applyStimulus(1'b0, 9'h022, 32'h0,         3'b101, 32'h0000_8001, 1'b0, 0, "lhu_22");
    applyStimulus(1'b0, 9'h020, 32'h0,         3'b010, 32'h8001_0000, 1'b0, 0, "lw_20");

    applyStimulus(1'b0, 9'h011, 32'h0,         3'b010, 32'h0000_0000, 1'b1, 0, "lw_mis_11");
    applyStimulus(1'b1, 9'h013, 32'h0000_1234, 3'b001, 32'h0000_0000, 1'b1, 0, "sh_mis_13");
    applyStimulus(1'b1, 9'h010, 32'hFFFF_FFFF, 3'b100, 32'h0000_0000, 1'b1, 0, "st_f3_100");
    applyStimulus(1'b0, 9'h010, 32'h0,         3'b010, 32'h7FAD_BEEF, 1'b0, 0, "lw_10_after_err");
    applyStimulus(1'b0, 9'h010, 32'h0,         3'b011, 32'h0000_0000, 1'b1, 0, "ld_f3_011");

    // Consumer stalls five cycles; the last response before the reset test
    // leaves a nonzero value in the response register.
    applyStimulus(1'b0, 9'h010, 32'h0,         3'b010, 32'h7FAD_BEEF, 1'b0, 5, "lw_stall");

    // Reset while the store sits in WAIT: it must be dropped silently.
    @(negedge clk);
    bus.req_valid  = 1'b1;
    bus.req_wr     = 1'b1;
    bus.req_addr   = 9'h030;
    bus.req_wdata  = 32'h1234_5678;
    bus.req_funct3 = 3'b010;
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    check("midwait_busy", 32'(bus.req_ready), 32'd0);
    reset = 1'b0;
    #1;
    check("midwait_rst_valid", 32'(bus.resp_valid), 32'd0);
    check("midwait_rst_rdata", bus.resp_rdata, 32'd0);
    check("midwait_rst_err", 32'(bus.resp_err), 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      #1;
      check("midwait_no_resp", 32'(bus.resp_valid), 32'd0);
      check("midwait_idle", 32'(bus.req_ready), 32'd1);
    end
    applyStimulus(1'b0, 9'h030, 32'h0, 3'b010, 32'h0000_0000, 1'b0, 0, "lw_30_after_rst");

    check("sb_drained", 32'(sbQ.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Global time limit so a stuck handshake still ends the run.
  initial begin
    #200000;
    $display("[TB] FAIL timeout observed=running required=finished");
    $fatal(1, "[TB] timeout");
  end

endmodule
